// File: rtl/memory_stage_unit.sv
// memory_stage_unit: memory (M) stage of the five-stage RISC-V pipeline.
// Issues loads and stores to a variable-latency data memory over a
// valid/ready request channel plus a response channel, holds the pipeline
// with Stall_M while an access is outstanding, and registers the results
// into the M/W pipeline register for writeback.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined   : a load whose response never arrives completes after
//               TIMEOUT_CYCLES waiting cycles with ReadData_W = 0 and a
//               one-cycle TimeoutErr_W pulse.
//   Undefined : no counter; the stage waits for the response indefinitely
//               and TimeoutErr_W is tied to 0.
module memory_stage_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite_M,
    input  logic                  MemWrite_M,
    input  logic [1:0]            ResultSrc_M,
    input  logic [31:0]           ALUResult_M,
    input  logic [31:0]           WriteData_M,
    input  logic [31:0]           PCPlus4_M,
    input  logic [4:0]            Rd_M,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_rsp_valid,
    input  logic [31:0]           dmem_rdata,
    output logic                  Stall_M,
    output logic                  RegWrite_W,
    output logic [1:0]            ResultSrc_W,
    output logic [31:0]           ALUResult_W,
    output logic [31:0]           ReadData_W,
    output logic [31:0]           PCPlus4_W,
    output logic [4:0]            Rd_W,
    output logic                  TimeoutErr_W
);

    typedef enum logic {
        IDLE,
        WAIT_RSP
    } state_t;

    state_t state_q, state_d;

    logic isLoad;
    logic isStore;
    logic memop;
    logic capture;
    logic loadDone;
    logic timeoutHit;

    logic        regWrite_q;
    logic [1:0]  resultSrc_q;
    logic [31:0] aluResult_q;
    logic [31:0] readData_q;
    logic [31:0] pcPlus4_q;
    logic [4:0]  rd_q;
    logic [31:0] readData_d;

    // A store takes priority when both store and load encodings are present,
    // so the load path is only taken for a pure load.
    assign isLoad  = (ResultSrc_M == 2'b01);
    assign isStore = MemWrite_M;
    assign memop   = isLoad | isStore;

    // Request payload follows the execute-stage outputs directly; the hazard
    // unit keeps them stable while the stage is stalled.
    assign dmem_addr  = ALUResult_M[ADDR_WIDTH-1:0];
    assign dmem_wdata = WriteData_M;
    assign dmem_we    = isStore;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          timeoutErr_q;

    // Counts waiting cycles without a response; restarts at zero whenever the
    // FSM is idle so each load begins its wait from zero.
    always_comb begin
        count_d = count_q;
        if (state_q == IDLE) begin
            count_d = '0;
        end else if (!dmem_rsp_valid) begin
            count_d = count_q + 1'b1;
        end
    end

    // Wait-cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The error flag lives in the M/W register for exactly the cycle in which
    // the timed-out load is presented to writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeoutErr_q <= 1'b0;
        end else begin
            timeoutErr_q <= timeoutHit;
        end
    end

    assign TimeoutErr_W = timeoutErr_q;
`else
    logic unusedTimeoutParam;

    assign unusedTimeoutParam = (TIMEOUT_CYCLES > 0);
    assign TimeoutErr_W       = 1'b0;
`endif

    // Next-state, handshake and stall decisions; reset forces the request and
    // stall low so an abandoned access leaves no stray handshake behind.
    always_comb begin
        state_d        = state_q;
        dmem_req_valid = 1'b0;
        Stall_M        = 1'b0;
        capture        = 1'b0;
        loadDone       = 1'b0;
        timeoutHit     = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (!memop) begin
                        capture = 1'b1;
                    end else begin
                        dmem_req_valid = 1'b1;
                        if (!dmem_req_ready) begin
                            Stall_M = 1'b1;
                        end else if (isStore) begin
                            capture = 1'b1;
                        end else begin
                            Stall_M = 1'b1;
                            state_d = WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        capture  = 1'b1;
                        loadDone = 1'b1;
                        state_d  = IDLE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        capture    = 1'b1;
                        timeoutHit = 1'b1;
                        state_d    = IDLE;
                    end
`endif
                    else begin
                        Stall_M = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only a load that actually received its response carries memory data;
    // every other completion (ALU op, store, timed-out load) writes zero.
    assign readData_d = loadDone ? dmem_rdata : 32'h0;

    // M/W pipeline register: captures the instruction on completion and
    // otherwise loads a bubble so a stalled instruction is never written twice.
    always_ff @(posedge clk) begin
        if (rst || !capture) begin
            regWrite_q  <= 1'b0;
            resultSrc_q <= 2'b00;
            aluResult_q <= 32'h0;
            readData_q  <= 32'h0;
            pcPlus4_q   <= 32'h0;
            rd_q        <= 5'd0;
        end else begin
            regWrite_q  <= RegWrite_M;
            resultSrc_q <= ResultSrc_M;
            aluResult_q <= ALUResult_M;
            readData_q  <= readData_d;
            pcPlus4_q   <= PCPlus4_M;
            rd_q        <= Rd_M;
        end
    end

    assign RegWrite_W  = regWrite_q;
    assign ResultSrc_W = resultSrc_q;
    assign ALUResult_W = aluResult_q;
    assign ReadData_W  = readData_q;
    assign PCPlus4_W   = pcPlus4_q;
    assign Rd_W        = rd_q;

endmodule

// File: tb/tb_memory_stage_unit.sv
// tb_memory_stage_unit: self-checking bench for memory_stage_unit.
// The bench plays the role of the data memory. Each instruction is described
// by how many cycles the memory keeps ready low and how many waiting cycles
// pass before the load response; from that the bench knows how long the
// instruction occupies the stage: a stall for every cycle except the last,
// a bubble in writeback after each stalled cycle, and the instruction's own
// fields after the last one.
module tb_memory_stage_unit;

`ifdef MEM_TIMEOUT_EN
    localparam int TCYC = 4;
`else
    localparam int TCYC = 16;
`endif

    logic        clk;
    logic        rst;
    logic        RegWrite_M;
    logic        MemWrite_M;
    logic [1:0]  ResultSrc_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic [31:0] PCPlus4_M;
    logic [4:0]  Rd_M;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        Stall_M;
    logic        RegWrite_W;
    logic [1:0]  ResultSrc_W;
    logic [31:0] ALUResult_W;
    logic [31:0] ReadData_W;
    logic [31:0] PCPlus4_W;
    logic [4:0]  Rd_W;
    logic        TimeoutErr_W;

    int checks = 0;
    int errors = 0;

    memory_stage_unit #(
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(TCYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .RegWrite_M    (RegWrite_M),
        .MemWrite_M    (MemWrite_M),
        .ResultSrc_M   (ResultSrc_M),
        .ALUResult_M   (ALUResult_M),
        .WriteData_M   (WriteData_M),
        .PCPlus4_M     (PCPlus4_M),
        .Rd_M          (Rd_M),
        .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata    (dmem_rdata),
        .Stall_M       (Stall_M),
        .RegWrite_W    (RegWrite_W),
        .ResultSrc_W   (ResultSrc_W),
        .ALUResult_W   (ALUResult_W),
        .ReadData_W    (ReadData_W),
        .PCPlus4_W     (PCPlus4_W),
        .Rd_W          (Rd_W),
        .TimeoutErr_W  (TimeoutErr_W)
    );

    // Free-running stage clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares the whole M/W register against an expected writeback record.
    task automatic checkW(input string tag, input logic rw, input logic [1:0] rs,
                          input logic [31:0] alu, input logic [31:0] rdd,
                          input logic [31:0] pc, input logic [4:0] rd, input logic te);
        checkOutput({tag, ".RegWrite_W"},   RegWrite_W,   rw);
        checkOutput({tag, ".ResultSrc_W"},  ResultSrc_W,  rs);
        checkOutput({tag, ".ALUResult_W"},  ALUResult_W,  alu);
        checkOutput({tag, ".ReadData_W"},   ReadData_W,   rdd);
        checkOutput({tag, ".PCPlus4_W"},    PCPlus4_W,    pc);
        checkOutput({tag, ".Rd_W"},         Rd_W,         rd);
        checkOutput({tag, ".TimeoutErr_W"}, TimeoutErr_W, te);
    endtask

    // Presents one instruction and plays the memory side for it. readyWait is
    // the number of cycles ready stays low; rspWait the number of waiting
    // cycles before a load response. Called just after a rising edge.
    task automatic applyStimulus(input string tag, input logic rw, input logic mw,
                                 input logic [1:0] rs, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [31:0] pc,
                                 input logic [4:0] rd, input int readyWait,
                                 input int rspWait, input logic [31:0] rdata);
        bit isStore;
        bit isLoad;
        int total;
        bit reqPhase;
        bit lastCycle;
        isStore = mw;
        isLoad  = (rs == 2'b01) && !mw;
        total   = isStore ? readyWait + 1 : (isLoad ? readyWait + 2 + rspWait : 1);
        RegWrite_M  = rw;
        MemWrite_M  = mw;
        ResultSrc_M = rs;
        ALUResult_M = alu;
        WriteData_M = wd;
        PCPlus4_M   = pc;
        Rd_M        = rd;
        for (int c = 0; c < total; c++) begin
            reqPhase       = (isStore || isLoad) && (c <= readyWait);
            lastCycle      = (c == total - 1);
            dmem_req_ready = reqPhase ? (c == readyWait) : 1'($urandom_range(0, 1));
            if (isLoad && lastCycle) begin
                dmem_rsp_valid = 1'b1;
                dmem_rdata     = rdata;
            end else begin
                dmem_rsp_valid = (isLoad && c > readyWait) ? 1'b0 : 1'($urandom_range(0, 1));
                dmem_rdata     = $urandom;
            end
            @(negedge clk);
            checkOutput({tag, ".Stall_M"}, Stall_M, !lastCycle);
            checkOutput({tag, ".req_valid"}, dmem_req_valid, reqPhase);
            if (reqPhase) begin
                checkOutput({tag, ".we"},    dmem_we,    isStore);
                checkOutput({tag, ".addr"},  dmem_addr,  alu);
                checkOutput({tag, ".wdata"}, dmem_wdata, wd);
            end
            @(posedge clk);
            #1;
            if (lastCycle) begin
                checkW(tag, rw, rs, alu, isLoad ? rdata : 32'h0, pc, rd, 1'b0);
            end else begin
                checkW({tag, ".bubble"}, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
            end
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
    endtask

    // Directed steps followed by a randomized instruction stream.
    initial begin
        logic [1:0] rsSel;
        int         kind;
        $display("[TB] memory_stage_unit bench start");
        rst            = 1'b1;
        RegWrite_M     = 1'b1;
        MemWrite_M     = 1'b1;
        ResultSrc_M    = 2'b01;
        ALUResult_M    = 32'h0000_0200;
        WriteData_M    = 32'h5555_AAAA;
        PCPlus4_M      = 32'h0000_0010;
        Rd_M           = 5'd3;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hFFFF_FFFF;

        // Reset holds the request and stall low even with a memop pending.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst.Stall_M", Stall_M, 1'b0);
            checkOutput("rst.req_valid", dmem_req_valid, 1'b0);
            @(posedge clk);
            #1;
            checkW("rst", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        end
        rst            = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;

        // ALU op, store with ready low for two cycles, load with a
        // three-cycle response wait, then an ALU op straight after the load.
        applyStimulus("alu", 1'b1, 1'b0, 2'b00, 32'h0000_0040, 32'h0, 32'h0000_1004, 5'd5, 0, 0, 32'h0);
        applyStimulus("store", 1'b0, 1'b1, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_1008, 5'd0, 2, 0, 32'h0);
        applyStimulus("load", 1'b1, 1'b0, 2'b01, 32'h0000_0180, 32'h0, 32'h0000_100C, 5'd7, 0, 3, 32'h1234_5678);
        applyStimulus("aluAfterLoad", 1'b1, 1'b0, 2'b00, 32'h0000_0099, 32'h0, 32'h0000_1010, 5'd9, 0, 0, 32'h0);
        applyStimulus("storeAndLoad", 1'b1, 1'b1, 2'b01, 32'h0000_0300, 32'hCAFE_F00D, 32'h0000_1014, 5'd11, 1, 0, 32'h0);
        applyStimulus("x0Write", 1'b1, 1'b0, 2'b10, 32'h0000_0077, 32'h0, 32'h0000_1018, 5'd0, 0, 0, 32'h0);

        // Reset while waiting for a load response, then a stale response
        // arriving in idle must be ignored.
        RegWrite_M     = 1'b1;
        MemWrite_M     = 1'b0;
        ResultSrc_M    = 2'b01;
        ALUResult_M    = 32'h0000_0400;
        PCPlus4_M      = 32'h0000_2000;
        Rd_M           = 5'd12;
        dmem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        dmem_req_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRst.Stall_M", Stall_M, 1'b0);
        checkOutput("midRst.req_valid", dmem_req_valid, 1'b0);
        @(posedge clk);
        #1;
        checkW("midRst", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        rst            = 1'b0;
        RegWrite_M     = 1'b0;
        ResultSrc_M    = 2'b00;
        ALUResult_M    = 32'h0;
        PCPlus4_M      = 32'h0;
        Rd_M           = 5'd0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hBAD0_BAD0;
        @(negedge clk);
        checkOutput("staleRsp.Stall_M", Stall_M, 1'b0);
        checkOutput("staleRsp.req_valid", dmem_req_valid, 1'b0);
        @(posedge clk);
        #1;
        checkW("staleRsp", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_rsp_valid = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // A load whose response never comes completes after TCYC waiting
        // cycles with zero data and a single error pulse.
        RegWrite_M     = 1'b1;
        MemWrite_M     = 1'b0;
        ResultSrc_M    = 2'b01;
        ALUResult_M    = 32'h0000_0500;
        PCPlus4_M      = 32'h0000_3000;
        Rd_M           = 5'd14;
        for (int c = 0; c <= TCYC; c++) begin
            dmem_req_ready = (c == 0);
            dmem_rsp_valid = 1'b0;
            @(negedge clk);
            checkOutput("timeout.Stall_M", Stall_M, c != TCYC);
            @(posedge clk);
            #1;
            if (c == TCYC) begin
                checkW("timeout", 1'b1, 2'b01, 32'h0000_0500, 32'h0, 32'h0000_3000, 5'd14, 1'b1);
            end else begin
                checkW("timeout.bubble", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
            end
        end
        dmem_req_ready = 1'b0;
        applyStimulus("aluAfterTimeout", 1'b1, 1'b0, 2'b00, 32'h0000_0123, 32'h0, 32'h0000_3004, 5'd15, 0, 0, 32'h0);
`endif

        // Randomized instruction mix with random memory latencies.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       rsSel = 2'b00;
                1:       rsSel = 2'b10;
                default: rsSel = 2'b11;
            endcase
            case (kind)
                0: applyStimulus("randAlu", 1'($urandom_range(0, 1)), 1'b0, rsSel, $urandom, $urandom,
                                 $urandom, 5'($urandom_range(0, 31)), 0, 0, 32'h0);
                1: applyStimulus("randStore", 1'($urandom_range(0, 1)), 1'b1, rsSel, $urandom, $urandom,
                                 $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 2), 0, 32'h0);
                2: applyStimulus("randLoad", 1'b1, 1'b0, 2'b01, $urandom, $urandom, $urandom,
                                 5'($urandom_range(0, 31)), $urandom_range(0, 2), $urandom_range(0, 3), $urandom);
                default: applyStimulus("randBoth", 1'b1, 1'b1, 2'b01, $urandom, $urandom, $urandom,
                                       5'($urandom_range(0, 31)), $urandom_range(0, 2), 0, 32'h0);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage_unit.md
Name: memory_stage_unit

Overview:
- Memory (M) stage of the 5-stage RISC-V pipeline, downstream of the execute stage.
- Consumes the execute-to-memory pipeline outputs and issues loads/stores to a variable-latency data memory over a valid/ready request channel plus a response channel.
- Raises Stall_M to the hazard unit while an access is outstanding.
- Registers results into the M/W pipeline register feeding writeback.

Parameters:
- ADDR_WIDTH, 32, width of dmem_addr; low ADDR_WIDTH bits of ALUResult_M.
- TIMEOUT_CYCLES, 16, WAIT_RSP cycle limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  stage clock.
- rst  in  1  synchronous, active-high reset.
- RegWrite_M  in  1  register-write enable from execute stage.
- MemWrite_M  in  1  store request.
- ResultSrc_M  in  2  00 = ALU, 01 = load data, 10 = PC+4.
- ALUResult_M  in  32  effective address or ALU result.
- WriteData_M  in  32  store data.
- PCPlus4_M  in  32  PC+4 of the instruction.
- Rd_M  in  5  destination register.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  ADDR_WIDTH  request address.
- dmem_wdata  out  32  store data.
- dmem_rsp_valid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- Stall_M  out  1  hold F/D/E/M stages this cycle.
- RegWrite_W  out  1  writeback enable.
- ResultSrc_W  out  2  writeback mux select.
- ALUResult_W  out  32  registered ALU result.
- ReadData_W  out  32  registered load data.
- PCPlus4_W  out  32  registered PC+4.
- Rd_W  out  5  registered destination register.
- TimeoutErr_W  out  1  load completed by timeout (MEM_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- One clock domain: clk. Reset: rst, synchronous, active-high.
- Reset: FSM to IDLE, counter cleared. All *_W outputs 0. dmem_req_valid = 0 and Stall_M = 0 while rst is high.
- Definitions: is_load = (ResultSrc_M == 01); is_store = MemWrite_M; memop = is_load | is_store. Both set: store wins (dmem_we = 1); W register still captures ResultSrc 01.
- Request payload (combinational): dmem_addr = ALUResult_M[ADDR_WIDTH-1:0]; dmem_wdata = WriteData_M; dmem_we = is_store.
- Input stability: inputs are held stable by the hazard unit while Stall_M = 1. Request payload and dmem_req_valid stay stable until accepted.
- FSM state IDLE:
  - No memop: dmem_req_valid = 0, Stall_M = 0. W register captures inputs next edge; ReadData_W = 0.
  - memop: dmem_req_valid = 1.
  - Store with ready = 1: completes this cycle (Stall_M = 0, W register captures, stay IDLE).
  - Load with ready = 1: Stall_M = 1, go to WAIT_RSP.
  - ready = 0: Stall_M = 1, stay IDLE.
- FSM state WAIT_RSP:
  - dmem_req_valid = 0.
  - rsp_valid = 0: Stall_M = 1.
  - rsp_valid = 1: Stall_M = 0, ReadData_W <= dmem_rdata, W register captures inputs, go to IDLE.
- Latencies: non-memop 1 cycle; store ≥ 1 cycle; load ≥ 2 cycles.
- Response sampling: dmem_rsp_valid is sampled only in WAIT_RSP. Responses in IDLE are ignored, including stale ones after a mid-access reset.
- Stall bubble: every cycle Stall_M = 1, the W register loads a bubble (RegWrite_W = 0, ResultSrc_W = 00, Rd_W = 0, data fields 0), preventing a duplicate register write.
- Reset mid-access: in-flight request abandoned, next cycle is IDLE with bubble outputs.
- Rd_M = 0 with RegWrite_M = 1: passed through unchanged; x0 suppression is the register file's job.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - Counter resets to 0 on entering WAIT_RSP and increments each WAIT_RSP cycle without a response.
  - When count reaches TIMEOUT_CYCLES-1 with no response: load completes with ReadData_W = 0 and TimeoutErr_W = 1 for that one W cycle; go to IDLE.
  - TimeoutErr_W = 0 otherwise.
- Undefined: no counter; WAIT_RSP waits indefinitely; TimeoutErr_W constant 0.

Test Plan:
- ALU op: RegWrite_M = 1, ResultSrc_M = 00, ALUResult_M = 0x0000_0040, Rd_M = 5 -> next cycle RegWrite_W = 1, ALUResult_W = 0x40, Rd_W = 5, Stall_M never 1.
- Store, ready low 2 cycles: MemWrite_M = 1, addr 0x100, data 0xDEADBEEF -> req_valid high 3 cycles with stable payload, we = 1; Stall_M = 1 for 2 cycles; then RegWrite_W = 0 bubble outputs during stall.
- Load, ready = 1, rsp after 3 WAIT_RSP cycles with rdata 0x12345678 -> Stall_M = 1 for 4 cycles; ReadData_W = 0x12345678, ResultSrc_W = 01, Rd_W as given; RegWrite_W = 1 exactly one cycle.
- Back-to-back load then ALU op: no dropped or duplicated W writes; ALU result appears one cycle after load completion.
- rst asserted in WAIT_RSP, rsp_valid pulsed cycle after rst deasserts -> IDLE, all *_W = 0, response ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, load with no response -> completes after 4 WAIT_RSP cycles; ReadData_W = 0, TimeoutErr_W = 1 one cycle.
